// File: rtl/clk_rst_seq_ctrl.sv
// clk_rst_seq_ctrl: staged release of N_DOM domain resets after power-on or
// software reset, plus glitch-safe clock-source switching (gate, switch, ungate).
// Optional feature macro: CLK_RST_SEQ_WDOG_EN adds a RUN-state watchdog
// (ports wdog_kick_i / wdog_evt_o) that fires a software-reset-equivalent.
module clk_rst_seq_ctrl #(
  parameter int N_DOM  = 4,
  parameter int DLY_W  = 8,
  parameter int WDOG_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             testmode_i,
  input  logic             sw_rst_req_i,
  input  logic             clk_sel_req_i,
  input  logic [DLY_W-1:0] dly_i,
`ifdef CLK_RST_SEQ_WDOG_EN
  input  logic             wdog_kick_i,
  output logic             wdog_evt_o,
`endif
  output logic             clk_sel_o,
  output logic             clk_en_o,
  output logic [N_DOM-1:0] dom_rst_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  typedef enum logic [2:0] {
    SEQ    = 3'd0,
    RUN    = 3'd1,
    GATE   = 3'd2,
    SWITCH = 3'd3,
    UNGATE = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [DLY_W-1:0]   cnt, cnt_n;
  logic               ph, ph_n;
  logic               pend, pend_n;
  logic [N_DOM-1:0]   dom_rst_r, dom_rst_n;
  logic               clk_en_r, clk_en_n;
  logic               clk_sel_r, clk_sel_n;
  logic               busy_r, busy_n;
  logic               done_r, done_n;

  logic               wdog_hit;
  logic               rst_req;
  logic [DLY_W-1:0]   dly_ld;
  logic [DLY_W-1:0]   cnt_eff;

  // A zero delay behaves as one cycle; cnt==0 marks "load from dly_i this cycle".
  assign dly_ld  = (dly_i == {DLY_W{1'b0}}) ? {{(DLY_W-1){1'b0}}, 1'b1} : dly_i;
  assign cnt_eff = (cnt == {DLY_W{1'b0}}) ? dly_ld : cnt;
  assign rst_req = sw_rst_req_i | wdog_hit;

`ifdef CLK_RST_SEQ_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_evt_r;

  // Fires on the edge where the counter would reach all-ones.
  assign wdog_hit = (state == RUN) && !wdog_kick_i &&
                    (wdog_cnt == {{(WDOG_W-1){1'b1}}, 1'b0});

  // Watchdog counter: runs only in RUN, cleared by kick, hit, or leaving RUN.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdog_cnt   <= {WDOG_W{1'b0}};
      wdog_evt_r <= 1'b0;
    end else begin
      wdog_evt_r <= wdog_hit;
      if ((state != RUN) || wdog_kick_i || wdog_hit) begin
        wdog_cnt <= {WDOG_W{1'b0}};
      end else begin
        wdog_cnt <= wdog_cnt + {{(WDOG_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign wdog_evt_o = wdog_evt_r;
`else
  assign wdog_hit = 1'b0;
`endif

  // Next-state and next-output logic for the sequencing / switching FSM.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt;
    ph_n      = ph;
    pend_n    = pend;
    dom_rst_n = dom_rst_r;
    clk_en_n  = clk_en_r;
    clk_sel_n = clk_sel_r;
    busy_n    = busy_r;
    done_n    = done_r;
    case (state)
      SEQ: begin
        clk_en_n = 1'b1;
        if (rst_req) begin
          dom_rst_n = {N_DOM{1'b1}};
          idx_n     = {IDX_W{1'b0}};
          cnt_n     = {DLY_W{1'b0}};
          busy_n    = 1'b1;
          done_n    = 1'b0;
        end else if (cnt_eff == {{(DLY_W-1){1'b0}}, 1'b1}) begin
          dom_rst_n[idx] = 1'b0;
          cnt_n          = dly_ld;
          if (idx == IDX_W'(N_DOM - 1)) begin
            state_n = RUN;
            idx_n   = {IDX_W{1'b0}};
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            idx_n = idx + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end else begin
          cnt_n = cnt_eff - {{(DLY_W-1){1'b0}}, 1'b1};
        end
      end
      RUN: begin
        // A reset request (new or deferred) takes priority over a pending switch.
        if (rst_req || pend) begin
          state_n   = SEQ;
          pend_n    = 1'b0;
          dom_rst_n = {N_DOM{1'b1}};
          idx_n     = {IDX_W{1'b0}};
          cnt_n     = {DLY_W{1'b0}};
          busy_n    = 1'b1;
          done_n    = 1'b0;
        end else if (clk_sel_req_i != clk_sel_r) begin
          state_n  = GATE;
          ph_n     = 1'b0;
          clk_en_n = 1'b0;
          busy_n   = 1'b1;
        end else begin
          state_n = RUN;
        end
      end
      GATE: begin
        if (rst_req) begin
          pend_n = 1'b1;
        end else begin
          pend_n = pend;
        end
        if (ph) begin
          state_n   = SWITCH;
          ph_n      = 1'b0;
          clk_sel_n = ~clk_sel_r;
        end else begin
          ph_n = 1'b1;
        end
      end
      SWITCH: begin
        if (rst_req) begin
          pend_n = 1'b1;
        end else begin
          pend_n = pend;
        end
        if (ph) begin
          state_n  = UNGATE;
          ph_n     = 1'b0;
          clk_en_n = 1'b1;
        end else begin
          ph_n = 1'b1;
        end
      end
      UNGATE: begin
        if (rst_req) begin
          pend_n = 1'b1;
        end else begin
          pend_n = pend;
        end
        state_n = RUN;
        busy_n  = 1'b0;
      end
      default: begin
        state_n   = SEQ;
        idx_n     = {IDX_W{1'b0}};
        cnt_n     = {DLY_W{1'b0}};
        ph_n      = 1'b0;
        pend_n    = 1'b0;
        dom_rst_n = {N_DOM{1'b1}};
        clk_en_n  = 1'b0;
        clk_sel_n = 1'b0;
        busy_n    = 1'b1;
        done_n    = 1'b0;
      end
    endcase
  end

  // State and registered-output flops; async reset returns to the power-on values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= SEQ;
      idx       <= {IDX_W{1'b0}};
      cnt       <= {DLY_W{1'b0}};
      ph        <= 1'b0;
      pend      <= 1'b0;
      dom_rst_r <= {N_DOM{1'b1}};
      clk_en_r  <= 1'b0;
      clk_sel_r <= 1'b0;
      busy_r    <= 1'b1;
      done_r    <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      ph        <= ph_n;
      pend      <= pend_n;
      dom_rst_r <= dom_rst_n;
      clk_en_r  <= clk_en_n;
      clk_sel_r <= clk_sel_n;
      busy_r    <= busy_n;
      done_r    <= done_n;
    end
  end

  // Test mode overrides the clock/reset controls combinationally; the FSM keeps running.
  assign dom_rst_o = testmode_i ? {N_DOM{rst_i}} : dom_rst_r;
  assign clk_en_o  = testmode_i ? 1'b1 : clk_en_r;
  assign clk_sel_o = testmode_i ? 1'b0 : clk_sel_r;
  assign busy_o    = busy_r;
  assign done_o    = done_r;

endmodule
